// File: rtl/handshake_push_pkg.sv
// Shared FSM encoding and width helper for the handshake push controller and its FIFO.
package handshake_push_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PUSH     = 2'd1,
      GUARD    = 2'd2,
      WAIT_RDY = 2'd3
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/push_fifo.sv
// Single-clock FWFT FIFO; head word visible while non-empty, write-to-read latency one edge.
// Backpressure: wr_rdy is a registered not-full flag, low during reset, with no write-through on a pop.
module push_fifo
   import handshake_push_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_vld,
   input  logic [DATA_WIDTH-1:0]    wr_dat,
   output logic                     wr_rdy,
   input  logic                     rd_pop,
   output logic                     rd_vld,
   output logic [DATA_WIDTH-1:0]    rd_dat,
   output logic [clog2(DEPTH):0]    level
);
   localparam int AW = clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   LVL_ONE  = 1;
   localparam logic [AW:0]   LVL_FULL = DEPTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           level_q, level_d;
   logic                  wr_rdy_q, wr_rdy_d;
   logic                  wr_en, rd_en;

   always_comb begin
      wr_en    = wr_vld & wr_rdy_q;
      rd_en    = rd_pop & (level_q != '0);
      wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      level_d  = level_q;
      if (wr_en && !rd_en) level_d = level_q + LVL_ONE;
      if (rd_en && !wr_en) level_d = level_q - LVL_ONE;
      // Ready tracks the post-edge level so a full FIFO refuses the very next word.
      wr_rdy_d = (level_d != LVL_FULL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         wr_rdy_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         wr_rdy_q <= wr_rdy_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_ptr_q] <= wr_dat;
   end

   assign wr_rdy = wr_rdy_q;
   assign rd_vld = (level_q != '0);
   assign rd_dat = mem_q[rd_ptr_q];
   assign level  = level_q;

endmodule

// File: rtl/handshake_push_ctrl.sv
// Feeds FIFO-buffered words one at a time to the CDC handshake: push pulse, guard cycle, wait for Ready.
// A word written at edge E0 pushes at E1 at the earliest; upstream stalls on o_iInReady while the FIFO is full.
module handshake_push_ctrl
   import handshake_push_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                          i_IClk,
   input  logic                          i_iReset,
   input  logic                          i_iValid,
   input  logic [DATA_WIDTH-1:0]         i_iWrData,
   output logic                          o_iInReady,
   output logic                          o_iPush,
   output logic [DATA_WIDTH-1:0]         o_iData,
   input  logic                          i_iReady,
   output logic [clog2(FIFO_DEPTH):0]    o_iLevel,
   output logic                          o_iBusy,
   output logic                          o_iTimeoutErr,
   input  logic                          i_iErrClr,
   output logic [CNT_WIDTH-1:0]          o_iSentCnt
);
   localparam int TW = (clog2(TIMEOUT_CYCLES + 1) > 0) ? clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [TW-1:0]        TMO_ONE  = 1;
   localparam logic [TW-1:0]        TMO_MAX  = TW'(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]        TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;

   state_e                  state_q, state_d;
   logic                    push_q, push_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic                    err_q, err_d;
   logic [CNT_WIDTH-1:0]    sent_q, sent_d;
   logic                    busy_q, busy_d;
   logic                    pop_en;
   logic                    fifo_vld;
   logic [DATA_WIDTH-1:0]   fifo_dat;

   push_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
   ) u_fifo (
      .clk    (i_IClk),
      .rst    (i_iReset),
      .wr_vld (i_iValid),
      .wr_dat (i_iWrData),
      .wr_rdy (o_iInReady),
      .rd_pop (pop_en),
      .rd_vld (fifo_vld),
      .rd_dat (fifo_dat),
      .level  (o_iLevel)
   );

   always_comb begin
      state_d = state_q;
      push_d  = 1'b0;
      data_d  = data_q;
      tmo_d   = tmo_q;
      err_d   = err_q;
      sent_d  = sent_q;
      pop_en  = 1'b0;
      if (i_iErrClr) err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (fifo_vld && i_iReady) begin
               state_d = PUSH;
               push_d  = 1'b1;
               data_d  = fifo_dat;
               pop_en  = 1'b1;
            end
         end
         PUSH:  state_d = GUARD;
         // Ready may still be stale-high here, so it is not looked at.
         GUARD: begin
            state_d = WAIT_RDY;
            tmo_d   = '0;
         end
         WAIT_RDY: begin
            if (i_iReady) begin
               state_d = IDLE;
               sent_d  = sent_q + CNT_ONE;
            end else begin
               if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_ONE;
               // Set fires only on the step into the limit, so a clear afterwards sticks.
               if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) err_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge i_IClk) begin
      if (i_iReset) begin
         state_q <= IDLE;
         push_q  <= 1'b0;
         data_q  <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         sent_q  <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         push_q  <= push_d;
         data_q  <= data_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         sent_q  <= sent_d;
         busy_q  <= busy_d;
      end
   end

   assign o_iPush       = push_q;
   assign o_iData       = data_q;
   assign o_iBusy       = busy_q;
   assign o_iTimeoutErr = err_q;
   assign o_iSentCnt    = sent_q;

endmodule

// File: tb/tb_handshake_push_ctrl.sv
// Randomized bench for handshake_push_ctrl against a transaction-level queue model of the FIFO and handshake.
module tb_handshake_push_ctrl;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int TMO   = 16;
   localparam int CW    = 4;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, valid, errclr;
   logic [DW-1:0] wr_data;
   logic          rsp_auto, rsp_val, auto_rdy;
   logic          i_ready;
   logic          o_in_ready, o_push, o_busy, o_err;
   logic [DW-1:0] o_data;
   logic [3:0]    o_level;
   logic [CW-1:0] o_sent;

   assign i_ready = rsp_auto ? auto_rdy : rsp_val;

   handshake_push_ctrl #(
      .DATA_WIDTH     (DW),
      .FIFO_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES (TMO),
      .CNT_WIDTH      (CW)
   ) dut (
      .i_IClk        (clk),
      .i_iReset      (rst),
      .i_iValid      (valid),
      .i_iWrData     (wr_data),
      .o_iInReady    (o_in_ready),
      .o_iPush       (o_push),
      .o_iData       (o_data),
      .i_iReady      (i_ready),
      .o_iLevel      (o_level),
      .o_iBusy       (o_busy),
      .o_iTimeoutErr (o_err),
      .i_iErrClr     (errclr),
      .o_iSentCnt    (o_sent)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Handshake responder: Ready stays stale-high one cycle after a push, then low for rsp_rt cycles.
   int rsp_rt  = 2;
   int rsp_cnt = 0;
   initial begin
      auto_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (o_push) rsp_cnt = rsp_rt + 1;
         else if (rsp_cnt > 0) begin
            rsp_cnt--;
            auto_rdy = (rsp_cnt == 0);
         end
      end
   end

   // Reference model: word queue plus outstanding-transfer bookkeeping.
   logic [DW-1:0] q_m[$];
   logic          pend_m = 1'b0, err_m = 1'b0, rdy_m = 1'b0, started = 1'b0;
   logic [DW-1:0] last_m = '0;
   logic [CW-1:0] sent_m = '0;
   logic [CW-1:0] prev_sent = '0;
   logic          push_exp, acc, set_err;
   int            edge_n = 0, pe_m = 0, wcnt_m = 0;
   int            last_push_e = -1, min_gap = 1000;
   bit            wrap_seen = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         edge_n++;
         push_exp = 1'b0;
         if (rst) begin
            q_m.delete();
            pend_m  = 1'b0;
            err_m   = 1'b0;
            sent_m  = '0;
            last_m  = '0;
            rdy_m   = 1'b0;
            started = 1'b1;
         end else if (started) begin
            push_exp = !pend_m && (q_m.size() != 0) && i_ready;
            acc      = valid && rdy_m;
            set_err  = 1'b0;
            if (pend_m && (edge_n - pe_m) >= 3) begin
               if (i_ready) begin
                  pend_m = 1'b0;
                  sent_m = sent_m + 1'b1;
               end else begin
                  wcnt_m++;
                  if (wcnt_m == TMO) set_err = 1'b1;
               end
            end
            if (push_exp) begin
               last_m = q_m.pop_front();
               pend_m = 1'b1;
               pe_m   = edge_n;
               wcnt_m = 0;
            end
            if (set_err) err_m = 1'b1;
            else if (errclr) err_m = 1'b0;
            if (acc) q_m.push_back(wr_data);
            rdy_m = (q_m.size() != DEPTH);
         end
         if (started) begin
            check_eq("push",   o_push,     push_exp);
            check_eq("data",   o_data,     last_m);
            check_eq("level",  o_level,    q_m.size());
            check_eq("in_rdy", o_in_ready, rdy_m);
            check_eq("busy",   o_busy,     pend_m);
            check_eq("err",    o_err,      err_m);
            check_eq("sent",   o_sent,     sent_m);
         end
         if (o_push === 1'b1) begin
            if (last_push_e >= 0 && (edge_n - last_push_e) < min_gap) min_gap = edge_n - last_push_e;
            last_push_e = edge_n;
         end
         if (!rst && prev_sent == 4'hF && o_sent == 4'h0) wrap_seen = 1'b1;
         prev_sent = o_sent;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_word(input logic [DW-1:0] w, input int budget, output bit ok);
      ok      = 1'b0;
      valid   = 1'b1;
      wr_data = w;
      for (int i = 0; i < budget && !ok; i++) begin
         ok = o_in_ready;
         @(negedge clk);
      end
      valid   = 1'b0;
      wr_data = $urandom;
   endtask

   task automatic wait_push(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk);
         ok = o_push;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit            ok;
      int            n_acc;
      logic [DW-1:0] w;
      rst      = 1'b1;
      valid    = 1'b0;
      wr_data  = '0;
      errclr   = 1'b0;
      rsp_auto = 1'b0;
      rsp_val  = 1'b1;
      tick(3);
      check_eq("rst_in_rdy", o_in_ready, 1'b0);
      rst = 1'b0;
      tick(1);
      check_eq("in_rdy_after_rst", o_in_ready, 1'b1);

      // Single word, Ready held high, short round trip.
      rsp_auto = 1'b1;
      rsp_rt   = 2;
      send_word(32'hA5A5_0001, 4, ok);
      check_eq("t1_accept", ok, 1'b1);
      tick(1);
      check_eq("t1_push", o_push, 1'b1);
      check_eq("t1_data", o_data, 32'hA5A5_0001);
      tick(1);
      check_eq("t1_push_one_cycle", o_push, 1'b0);
      tick(12);
      check_eq("t1_sent", o_sent, 1);
      check_eq("t1_busy", o_busy, 1'b0);

      // Burst of 9 with Ready low: 8 fit, the 9th is held off.
      rsp_auto = 1'b0;
      rsp_val  = 1'b0;
      n_acc    = 0;
      for (int i = 0; i < 9; i++) begin
         w = $urandom;
         send_word(w, (i < 8) ? 2 : 4, ok);
         if (ok) n_acc++;
      end
      check_eq("t2_accepted", n_acc, 8);
      check_eq("t2_level", o_level, 8);
      check_eq("t2_in_rdy", o_in_ready, 1'b0);

      // Drain with a 6-cycle round trip.
      rsp_rt      = 6;
      rsp_auto    = 1'b1;
      last_push_e = -1;
      min_gap     = 1000;
      for (int i = 0; i < 300 && o_sent != 4'd9; i++) tick(1);
      check_eq("t3_sent", o_sent, 9);
      check_eq("t3_gap_ge_9", (min_gap >= 9), 1'b1);
      tick(2);
      check_eq("t3_level", o_level, 0);

      // Timeout with Ready stuck low, then clear and recover.
      rsp_auto = 1'b0;
      rsp_val  = 1'b1;
      send_word($urandom, 4, ok);
      wait_push(6, ok);
      check_eq("t4_push_seen", ok, 1'b1);
      rsp_val = 1'b0;
      tick(17);
      check_eq("t4_err_before", o_err, 1'b0);
      tick(1);
      check_eq("t4_err_set", o_err, 1'b1);
      tick(3);
      errclr = 1'b1;
      tick(1);
      errclr = 1'b0;
      check_eq("t4_err_clr", o_err, 1'b0);
      tick(2);
      check_eq("t4_err_stays_clr", o_err, 1'b0);
      rsp_val = 1'b1;
      tick(2);
      check_eq("t4_sent", o_sent, 10);
      check_eq("t4_busy", o_busy, 1'b0);

      // Reset while waiting with 3 words queued.
      send_word($urandom, 4, ok);
      wait_push(6, ok);
      rsp_val = 1'b0;
      for (int i = 0; i < 3; i++) send_word($urandom, 3, ok);
      tick(2);
      check_eq("t5_level_pre", o_level, 3);
      check_eq("t5_busy_pre", o_busy, 1'b1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check_eq("t5_level", o_level, 0);
      check_eq("t5_push", o_push, 1'b0);
      check_eq("t5_busy", o_busy, 1'b0);
      check_eq("t5_sent", o_sent, 0);
      rsp_val = 1'b1;
      tick(8);
      check_eq("t5_idle_busy", o_busy, 1'b0);
      send_word(32'hD00D_0001, 4, ok);
      wait_push(4, ok);
      check_eq("t5_new_push", ok, 1'b1);
      check_eq("t5_new_data", o_data, 32'hD00D_0001);
      tick(6);

      // Write and pop on the same edge at level 4.
      rsp_val = 1'b0;
      for (int i = 0; i < 4; i++) send_word($urandom, 3, ok);
      check_eq("t6_level4", o_level, 4);
      rsp_val = 1'b1;
      valid   = 1'b1;
      wr_data = $urandom;
      tick(1);
      valid   = 1'b0;
      check_eq("t6_pop", o_push, 1'b1);
      check_eq("t6_level_same", o_level, 4);

      // Many quick transfers so the sent counter wraps.
      rsp_rt    = 0;
      rsp_auto  = 1'b1;
      wrap_seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         send_word($urandom, 30, ok);
         if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 4));
      end
      for (int i = 0; i < 300 && (o_level != 0 || o_busy); i++) tick(1);
      check_eq("t6_drained", o_level, 0);
      check_eq("t6_wrap_seen", wrap_seen, 1'b1);
      tick(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
